enq_credit_gate: RTL and testbench

- Parametrised successor to the two-queue decode replay gate. Sits between the block decoder and NQ downstream command/immediate queues.
- Tracks a per-queue credit count and issues an instruction only when every queue it targets has credit. Otherwise it raises replay.
- Adds credit return, all-or-nothing multi-queue enqueue, a starvation watchdog and a sticky credit-overflow error.

---
 rtl/enq_gate_pkg.sv | 22 ++
 rtl/enq_credit_counter.sv | 46 ++++
 rtl/enq_credit_gate.sv | 81 ++++++++
 tb/tb_enq_credit_gate.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/enq_gate_pkg.sv
// Shared defaults and helpers for the enqueue credit gate.
package enq_gate_pkg;

  localparam int unsigned DEF_NQ           = 2;
  localparam int unsigned DEF_MAX_CREDIT   = 8;
  localparam int unsigned DEF_CREDIT_W     = 8;
  localparam int unsigned DEF_STARVE_LIMIT = 15;

  // Ceiling log2; clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned p = 1; p < v; p = p << 1) r = r + 1;
    return r;
  endfunction

  // LSB position of queue q's counter inside the packed credit bus.
  function automatic int unsigned credit_lsb(input int unsigned q, input int unsigned w);
    return q * w;
  endfunction

endpackage

// File: rtl/enq_credit_counter.sv
// Per-queue credit counter: consumes on take, refills on ret, flags
// a return into an already-full counter.
module enq_credit_counter
  import enq_gate_pkg::*;
#(
  parameter int unsigned CREDIT_W   = DEF_CREDIT_W,
  parameter int unsigned MAX_CREDIT = DEF_MAX_CREDIT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_take,
  input  logic                i_ret,
  output logic [CREDIT_W-1:0] o_credit,
  output logic                o_ready,
  output logic                o_overflow
);

  localparam logic [CREDIT_W-1:0] MAX_C = CREDIT_W'(MAX_CREDIT);

  logic [CREDIT_W-1:0] r_credit;
  logic [CREDIT_W-1:0] w_credit_nxt;

  // Next credit value and overflow pulse; take and ret together cancel.
  always_comb begin
    w_credit_nxt = r_credit;
    o_overflow   = 1'b0;
    case ({i_take, i_ret})
      2'b10: w_credit_nxt = r_credit - CREDIT_W'(1);
      2'b01: begin
        if (r_credit == MAX_C) o_overflow   = 1'b1;
        else                   w_credit_nxt = r_credit + CREDIT_W'(1);
      end
      default: ;
    endcase
  end

  // Credit register, full on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_credit <= MAX_C;
    else        r_credit <= w_credit_nxt;
  end

  assign o_credit = r_credit;
  assign o_ready  = (r_credit != '0);

endmodule

// File: rtl/enq_credit_gate.sv
// Decode-to-queue credit gate: issues an instruction only when every
// targeted queue has credit, otherwise replays; tracks replay streaks
// and latches credit-return overflow.
module enq_credit_gate
  import enq_gate_pkg::*;
#(
  parameter int unsigned NQ           = DEF_NQ,
  parameter int unsigned MAX_CREDIT   = DEF_MAX_CREDIT,
  parameter int unsigned CREDIT_W     = DEF_CREDIT_W,
  parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   io_valid,
  input  logic [NQ-1:0]          io_sigs_enq,
  input  logic [NQ-1:0]          io_deq,
  output logic                   io_fire,
  output logic                   io_replay,
  output logic [NQ-1:0]          io_enq_valid,
  output logic [NQ*CREDIT_W-1:0] io_credits,
  output logic                   io_starve,
  output logic                   io_credit_err
);

  localparam int unsigned        RCNT_W = clog2(STARVE_LIMIT + 1);
  localparam logic [RCNT_W-1:0]  LIMIT  = RCNT_W'(STARVE_LIMIT);

  logic [NQ-1:0]     w_ready;
  logic [NQ-1:0]     w_ovf;
  logic              w_blocked;
  logic [RCNT_W-1:0] w_rcnt_nxt;
  logic [RCNT_W-1:0] r_rcnt;
  logic              r_starve;
  logic              r_err;

  for (genvar g = 0; g < NQ; g++) begin : g_q
    enq_credit_counter #(
      .CREDIT_W  (CREDIT_W),
      .MAX_CREDIT(MAX_CREDIT)
    ) u_cnt (
      .clk       (clk),
      .rst_n     (reset),
      .i_take    (io_enq_valid[g]),
      .i_ret     (io_deq[g]),
      .o_credit  (io_credits[credit_lsb(g, CREDIT_W) +: CREDIT_W]),
      .o_ready   (w_ready[g]),
      .o_overflow(w_ovf[g])
    );
  end

  // Issue decision from registered credit only; all-or-nothing strobes.
  always_comb begin
    w_blocked    = |(io_sigs_enq & ~w_ready);
    io_fire      = io_valid & ~w_blocked;
    io_replay    = io_valid & w_blocked;
    io_enq_valid = io_fire ? io_sigs_enq : '0;
  end

  // Replay streak: saturating count while replaying, cleared otherwise.
  always_comb begin
    w_rcnt_nxt = '0;
    if (io_replay) w_rcnt_nxt = (r_rcnt == LIMIT) ? r_rcnt : r_rcnt + RCNT_W'(1);
  end

  // Streak counter, starve flag and sticky overflow error.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rcnt   <= '0;
      r_starve <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_rcnt   <= w_rcnt_nxt;
      r_starve <= (w_rcnt_nxt == LIMIT);
      r_err    <= r_err | (|w_ovf);
    end
  end

  assign io_starve     = r_starve;
  assign io_credit_err = r_err;

endmodule

// File: tb/tb_enq_credit_gate.sv
// Directed bench for enq_credit_gate with NQ=2, MAX_CREDIT=2, CREDIT_W=2,
// STARVE_LIMIT=3. io_credits = {credit1, credit0}.
module tb_enq_credit_gate;

  logic       clk = 1'b0;
  logic       reset;
  logic       io_valid;
  logic [1:0] io_sigs_enq;
  logic [1:0] io_deq;
  logic       io_fire;
  logic       io_replay;
  logic [1:0] io_enq_valid;
  logic [3:0] io_credits;
  logic       io_starve;
  logic       io_credit_err;

  int n_total = 0;
  int n_bad   = 0;

  enq_credit_gate #(
    .NQ          (2),
    .MAX_CREDIT  (2),
    .CREDIT_W    (2),
    .STARVE_LIMIT(3)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .io_valid     (io_valid),
    .io_sigs_enq  (io_sigs_enq),
    .io_deq       (io_deq),
    .io_fire      (io_fire),
    .io_replay    (io_replay),
    .io_enq_valid (io_enq_valid),
    .io_credits   (io_credits),
    .io_starve    (io_starve),
    .io_credit_err(io_credit_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // fire / replay / enq_valid together
  task automatic chk_out(input string tag, input logic f, input logic r, input logic [1:0] e);
    chk({tag, ".fire"},   32'(io_fire),      32'(f));
    chk({tag, ".replay"}, 32'(io_replay),    32'(r));
    chk({tag, ".enq"},    32'(io_enq_valid), 32'(e));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] s, input logic [1:0] d);
    io_valid    = v;
    io_sigs_enq = s;
    io_deq      = d;
    #1;
  endtask

  initial begin
    reset = 1'b0;
    io_valid = 1'b0; io_sigs_enq = 2'b00; io_deq = 2'b00;
    #12;
    chk("rst.credits", 32'(io_credits), 32'hA);
    chk("rst.starve",  32'(io_starve), 0);
    chk("rst.err",     32'(io_credit_err), 0);
    chk_out("rst", 1'b0, 1'b0, 2'b00);
    reset = 1'b1;
    tick();

    // Drain queue 0: two fires then replay.
    drive(1'b1, 2'b01, 2'b00);
    chk_out("c1", 1'b1, 1'b0, 2'b01);
    chk("c1.credits", 32'(io_credits), 32'hA);
    tick();
    drive(1'b1, 2'b01, 2'b00);
    chk_out("c2", 1'b1, 1'b0, 2'b01);
    chk("c2.credits", 32'(io_credits), 32'h9);
    tick();
    drive(1'b1, 2'b01, 2'b00);
    chk_out("c3", 1'b0, 1'b1, 2'b00);
    chk("c3.credits", 32'(io_credits), 32'h8);
    chk("c3.starve", 32'(io_starve), 0);
    tick();
    chk_out("c4", 1'b0, 1'b1, 2'b00);
    chk("c4.credits", 32'(io_credits), 32'h8);
    chk("c4.starve", 32'(io_starve), 0);
    tick();
    chk("c5.starve", 32'(io_starve), 0);
    tick();
    // Three replays done: starve now up. Return a credit; not usable yet.
    chk("c6.starve", 32'(io_starve), 1);
    drive(1'b1, 2'b01, 2'b01);
    chk_out("c6", 1'b0, 1'b1, 2'b00);
    tick();
    drive(1'b1, 2'b01, 2'b00);
    chk("c7.credits", 32'(io_credits), 32'h9);
    chk_out("c7", 1'b1, 1'b0, 2'b01);
    chk("c7.starve", 32'(io_starve), 1);
    tick();
    chk("c8.starve", 32'(io_starve), 0);
    chk("c8.credits", 32'(io_credits), 32'h8);
    // Take one credit from queue 1 to reach credits {c1=1, c0=0}.
    drive(1'b1, 2'b10, 2'b00);
    chk_out("c8", 1'b1, 1'b0, 2'b10);
    tick();
    drive(1'b1, 2'b01, 2'b00);
    chk("c9.credits", 32'(io_credits), 32'h4);
    tick();
    tick();
    tick();
    chk("c12.starve", 32'(io_starve), 1);
    chk("c12.credits", 32'(io_credits), 32'h4);

    // Asynchronous reset mid-cycle.
    reset = 1'b0;
    #1;
    chk("mrst.credits", 32'(io_credits), 32'hA);
    chk("mrst.starve",  32'(io_starve), 0);
    chk("mrst.err",     32'(io_credit_err), 0);
    drive(1'b0, 2'b01, 2'b00);
    chk_out("mrst", 1'b0, 1'b0, 2'b00);
    reset = 1'b1;
    tick();

    // Take and return in the same cycle.
    drive(1'b1, 2'b01, 2'b00);
    tick();
    chk("tr.pre", 32'(io_credits), 32'h9);
    drive(1'b1, 2'b01, 2'b01);
    chk_out("tr", 1'b1, 1'b0, 2'b01);
    tick();
    chk("tr.credits", 32'(io_credits), 32'h9);
    chk("tr.err", 32'(io_credit_err), 0);
    // Take and return at MAX_CREDIT: no error.
    drive(1'b1, 2'b10, 2'b10);
    chk_out("trmax", 1'b1, 1'b0, 2'b10);
    tick();
    chk("trmax.credits", 32'(io_credits), 32'h9);
    chk("trmax.err", 32'(io_credit_err), 0);

    // Drain queue 0, then all-or-nothing on sigs=11.
    drive(1'b1, 2'b01, 2'b00);
    tick();
    drive(1'b1, 2'b11, 2'b00);
    chk_out("aon", 1'b0, 1'b1, 2'b00);
    tick();
    chk("aon.credits", 32'(io_credits), 32'h8);
    drive(1'b1, 2'b00, 2'b00);
    chk_out("nosig", 1'b1, 1'b0, 2'b00);
    tick();
    chk("nosig.credits", 32'(io_credits), 32'h8);
    drive(1'b0, 2'b11, 2'b00);
    chk_out("idle", 1'b0, 1'b0, 2'b00);
    tick();

    // Return into a full counter: sticky error.
    drive(1'b0, 2'b00, 2'b10);
    tick();
    chk("ovf.credits", 32'(io_credits), 32'h8);
    chk("ovf.err", 32'(io_credit_err), 1);
    drive(1'b0, 2'b00, 2'b01);
    tick();
    chk("ovf2.credits", 32'(io_credits), 32'h9);
    chk("ovf2.err", 32'(io_credit_err), 1);
    drive(1'b1, 2'b01, 2'b00);
    chk_out("ovf3", 1'b1, 1'b0, 2'b01);
    tick();
    drive(1'b0, 2'b00, 2'b00);
    chk("ovf3.credits", 32'(io_credits), 32'h8);
    chk("ovf3.err", 32'(io_credit_err), 1);
    reset = 1'b0;
    #1;
    chk("ovfrst.err", 32'(io_credit_err), 0);
    reset = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
